// File: rtl/ppu_bg_fetcher.sv
// Background tile fetcher: walks the BG tile map for one scanline, reads tile bytes from
// VRAM and streams 2-bit colour indices to the LCD pixel pipe through a 16-entry FIFO.
//
// state  | meaning
// IDLE   | no line in progress, VRAM released
// MAP_RD | reading tile number from the BG map
// LO_RD  | reading low bitplane byte of the tile row
// HI_RD  | reading high bitplane byte of the tile row
// PUSH   | waiting for FIFO room, then writing 8 decoded pixels
// DRAIN  | all tiles fetched, emitting the remaining pixels
module ppu_bg_fetcher #(
    parameter int RD_WAIT  = 1,
    parameter int LINE_PIX = 160
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  LCDC,
    input  logic [7:0]  SCY,
    input  logic [7:0]  SCX,
    input  logic [7:0]  LY,
    input  logic [7:0]  ppu_data_in,
    output logic [12:0] ppu_addr,
    output logic        ppu_vram_read_en,
    output logic        ppu_oam_read_en,
    output logic        ppu_read_mode,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [1:0]  pix_color,
    output logic        busy,
    output logic        line_done
);

    localparam int         PIX_W          = $clog2(LINE_PIX + 1);
    localparam logic [4:0] TILES_PER_LINE = 5'd21;
    localparam logic [1:0] WAIT_LOAD      = 2'(RD_WAIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAP_RD = 3'd1,
        LO_RD  = 3'd2,
        HI_RD  = 3'd3,
        PUSH   = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic             bg_en_q, map_sel_q, data_sel_q;
    logic [7:0]       y_q;
    logic [4:0]       col_q;
    logic [2:0]       disc_q;
    logic [PIX_W-1:0] pix_left_q;
    logic [4:0]       tiles_left_q;
    logic [1:0]       wait_q;
    logic [7:0]       tile_q, lo_q, hi_q;
    logic [1:0]       fifo_q [16];
    logic [4:0]       fifo_cnt_q;
    logic             line_done_q;

    logic        rd_done, push_ok, start_go;
    logic        pop_disc, accept, pop, line_end;
    logic [12:0] map_addr, tile_base, lo_addr, hi_addr;
    logic [1:0]  new_pix [8];
    logic [1:0]  fifo_d [16];
    logic [4:0]  cnt_after_pop, cnt_d;

    assign rd_done   = (wait_q == 2'd0);
    assign push_ok   = (state_q == PUSH) && (fifo_cnt_q <= 5'd8);
    assign start_go  = line_start && LCDC[7];
    assign pop_disc  = (disc_q != 3'd0) && (fifo_cnt_q != 5'd0);
    assign pix_valid = (fifo_cnt_q != 5'd0) && (disc_q == 3'd0) && (pix_left_q != '0);
    assign accept    = pix_valid && pix_ready;
    assign pop       = pop_disc || accept;
    assign line_end  = accept && (pix_left_q == PIX_W'(1));

    // 13-bit VRAM offsets; carries past 0x1FFF are dropped on purpose
    assign map_addr  = (map_sel_q ? 13'h1C00 : 13'h1800) + {3'b000, y_q[7:3], col_q};
    assign tile_base = data_sel_q ? {1'b0, tile_q, 4'b0000}
                                  : 13'h1000 + {tile_q[7], tile_q, 4'b0000};
    assign lo_addr   = tile_base + {9'd0, y_q[2:0], 1'b0};
    assign hi_addr   = lo_addr + 13'd1;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            new_pix[i] = bg_en_q ? {hi_q[3'(7 - i)], lo_q[3'(7 - i)]} : 2'b00;
        end
    end

    // Pop shifts the FIFO toward entry 0; the 8 new pixels land behind the survivors.
    always_comb begin
        cnt_after_pop = fifo_cnt_q - 5'(pop);
        for (int j = 0; j < 16; j++) begin
            fifo_d[j] = fifo_q[j];
        end
        if (pop) begin
            for (int j = 0; j < 15; j++) begin
                fifo_d[j] = fifo_q[j + 1];
            end
            fifo_d[15] = 2'b00;
        end
        if (push_ok) begin
            for (int j = 0; j < 16; j++) begin
                if ((5'(j) >= cnt_after_pop) && (5'(j) < cnt_after_pop + 5'd8)) begin
                    fifo_d[j] = new_pix[3'(5'(j) - cnt_after_pop)];
                end
            end
        end
        cnt_d = cnt_after_pop + (push_ok ? 5'd8 : 5'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            MAP_RD:  if (rd_done) state_d = LO_RD;
            LO_RD:   if (rd_done) state_d = HI_RD;
            HI_RD:   if (rd_done) state_d = PUSH;
            PUSH:    if (push_ok) state_d = (tiles_left_q == 5'd1) ? DRAIN : MAP_RD;
            DRAIN:   state_d = DRAIN;
            default: state_d = IDLE;
        endcase
        if (line_end) begin
            state_d = IDLE;
        end
        if (line_start) begin
            state_d = start_go ? MAP_RD : IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bg_en_q      <= 1'b0;
            map_sel_q    <= 1'b0;
            data_sel_q   <= 1'b0;
            y_q          <= 8'd0;
            col_q        <= 5'd0;
            disc_q       <= 3'd0;
            pix_left_q   <= '0;
            tiles_left_q <= 5'd0;
            wait_q       <= 2'd0;
            tile_q       <= 8'd0;
            lo_q         <= 8'd0;
            hi_q         <= 8'd0;
            line_done_q  <= 1'b0;
        end else begin
            line_done_q <= line_end && !line_start;
            if (line_start || (state_d != state_q)) begin
                wait_q <= WAIT_LOAD;
            end else if (wait_q != 2'd0) begin
                wait_q <= wait_q - 2'd1;
            end
            if (start_go) begin
                bg_en_q      <= LCDC[0];
                map_sel_q    <= LCDC[3];
                data_sel_q   <= LCDC[4];
                y_q          <= LY + SCY;
                col_q        <= SCX[7:3];
                disc_q       <= SCX[2:0];
                pix_left_q   <= PIX_W'(LINE_PIX);
                tiles_left_q <= TILES_PER_LINE;
            end else begin
                case (state_q)
                    MAP_RD: if (rd_done) tile_q <= ppu_data_in;
                    LO_RD:  if (rd_done) lo_q <= ppu_data_in;
                    HI_RD:  if (rd_done) hi_q <= ppu_data_in;
                    PUSH: begin
                        if (push_ok) begin
                            col_q        <= col_q + 5'd1;
                            tiles_left_q <= tiles_left_q - 5'd1;
                        end
                    end
                    default: ;
                endcase
                if (pop_disc) begin
                    disc_q <= disc_q - 3'd1;
                end
                if (accept) begin
                    pix_left_q <= pix_left_q - PIX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_cnt_q <= 5'd0;
            for (int j = 0; j < 16; j++) begin
                fifo_q[j] <= 2'b00;
            end
        end else if (line_start || line_end) begin
            fifo_cnt_q <= 5'd0;
        end else begin
            fifo_cnt_q <= cnt_d;
            for (int j = 0; j < 16; j++) begin
                fifo_q[j] <= fifo_d[j];
            end
        end
    end

    always_comb begin
        ppu_addr = 13'd0;
        case (state_q)
            MAP_RD:      ppu_addr = map_addr;
            LO_RD:       ppu_addr = lo_addr;
            HI_RD, PUSH: ppu_addr = hi_addr;
            default:     ppu_addr = 13'd0;
        endcase
    end

    assign ppu_vram_read_en = (state_q == MAP_RD) || (state_q == LO_RD) ||
                              (state_q == HI_RD)  || (state_q == PUSH);
    assign ppu_oam_read_en  = 1'b0;
    assign ppu_read_mode    = 1'b1;
    assign busy             = (state_q != IDLE);
    assign line_done        = line_done_q;
    assign pix_color        = pix_valid ? fifo_q[0] : 2'b00;

endmodule
